// File: rtl/darkriscv_dbus_bridge.sv
// Data-bus bridge from the darkriscv core data port to a word-wide memory port with byte enables.
// Stalls the core via HLT while busy; traps misaligned/illegal/timed-out accesses in a sticky error register.
module darkriscv_dbus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        DAS,
  input  logic        DRD,
  input  logic        DWR,
  input  logic [2:0]  DLEN,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  input  logic        ERR_CLR,
  output logic        ERR,
  output logic [31:0] ERR_ADDR
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic [31:0] addr_q;
  logic        rd_q;
  logic        start, bad, tmo_hit, err_set;
  logic [31:0] err_addr_new;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Lane steering and legality check for the request currently on the core port.
  always_comb begin
    be    = 4'b0000;
    wdata = DATAO;
    bad   = 1'b0;
    case (DLEN)
      3'd1: begin
        be    = 4'b0001 << DADDR[1:0];
        wdata = {4{DATAO[7:0]}};
      end
      3'd2: begin
        be    = 4'b0011 << DADDR[1:0];
        wdata = {2{DATAO[15:0]}};
        bad   = DADDR[0];
      end
      3'd4: begin
        be  = 4'hF;
        bad = |DADDR[1:0];
      end
      default: bad = 1'b1;
    endcase
    if (DRD && DWR) bad = 1'b1;
  end

  assign start   = DAS && (DRD || DWR);
  assign tmo_hit = (state == BUSY) && !MEM_ACK && (tmo_cnt == TMO_LAST);
  assign HLT     = !RES && (((state == IDLE) && start) || (state == BUSY));

  always_ff @(posedge CLK) begin
    if (RES) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    err_set      = 1'b0;
    err_addr_new = addr_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad) begin
            state_nxt    = DONE;
            err_set      = 1'b1;
            err_addr_new = DADDR;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (MEM_ACK) begin
          state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      DATAI     <= 32'h0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_BE    <= 4'h0;
      MEM_ADDR  <= 32'h0;
      MEM_WDATA <= 32'h0;
      addr_q    <= 32'h0;
      rd_q      <= 1'b0;
      tmo_cnt   <= 16'h0;
      ERR       <= 1'b0;
      ERR_ADDR  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !bad) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= DWR;
            MEM_BE    <= be;
            MEM_ADDR  <= {DADDR[31:2], 2'b00};
            MEM_WDATA <= wdata;
            addr_q    <= DADDR;
            rd_q      <= DRD;
            tmo_cnt   <= 16'h0;
          end else if (start && DRD) begin
            DATAI <= 32'h0;
          end
        end
        BUSY: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            if (rd_q) DATAI <= MEM_RDATA;
          end else if (tmo_hit) begin
            MEM_REQ <= 1'b0;
            DATAI   <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase

      // A fresh error beats a simultaneous clear and re-arms the address capture.
      if (err_set) begin
        ERR <= 1'b1;
        if (!ERR || ERR_CLR) ERR_ADDR <= err_addr_new;
      end else if (ERR_CLR) begin
        ERR      <= 1'b0;
        ERR_ADDR <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_darkriscv_dbus_bridge.sv
// Scoreboard bench: stimulus queues expected memory requests and completions; a monitor checks them.
module tb_darkriscv_dbus_bridge;

  logic        CLK = 1'b0;
  logic        RES, DAS, DRD, DWR, MEM_ACK, ERR_CLR;
  logic [2:0]  DLEN;
  logic [31:0] DADDR, DATAO, MEM_RDATA;
  logic [31:0] DATAI, MEM_ADDR, MEM_WDATA, ERR_ADDR;
  logic        HLT, MEM_REQ, MEM_WE, ERR;
  logic [3:0]  MEM_BE;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } req_t;

  typedef struct {
    logic [31:0] datai;
    logic        err;
    logic [31:0] eaddr;
    int          hlt;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  int vectors = 0;
  int miscompares = 0;
  int ack_on = 0;
  logic [31:0] rdata_v = 32'h0;
  logic force_ack = 1'b0;

  darkriscv_dbus_bridge #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RES(RES), .DAS(DAS), .DRD(DRD), .DWR(DWR), .DLEN(DLEN),
    .DADDR(DADDR), .DATAO(DATAO), .DATAI(DATAI), .HLT(HLT),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .ERR_CLR(ERR_CLR), .ERR(ERR), .ERR_ADDR(ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic exp_q(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input int len);
    req_t r;
    r.we = we; r.be = be; r.addr = a; r.wdata = wd; r.len = len;
    exp_req.push_back(r);
  endtask

  task automatic exp_r(input logic [31:0] d, input logic e, input logic [31:0] ea, input int h);
    rsp_t r;
    r.datai = d; r.err = e; r.eaddr = ea; r.hlt = h;
    exp_rsp.push_back(r);
  endtask

  // Core-side access: hold the request while HLT is high, drop it in the completion cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] len,
                           input logic [31:0] a, input logic [31:0] d,
                           input int ack, input logic [31:0] rdat, input logic clr);
    int guard;
    @(negedge CLK);
    ack_on = ack; rdata_v = rdat;
    DAS = 1'b1; DRD = rd; DWR = wr; DLEN = len; DADDR = a; DATAO = d; ERR_CLR = clr;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    guard = 0;
    while (HLT && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 50) chk("hlt_release_timeout", 32'(HLT), 32'h0);
    DAS = 1'b0; DRD = 1'b0; DWR = 1'b0;
  endtask

  task automatic clr_err();
    @(negedge CLK);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    chk("clr_err", 32'(ERR), 32'h0);
    chk("clr_err_addr", ERR_ADDR, 32'h0);
  endtask

  // Memory model: acks on the ack_on-th cycle of a request (0 = never).
  initial begin
    int n;
    n = 0;
    MEM_ACK = 1'b0;
    MEM_RDATA = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (MEM_REQ) begin
        n++;
        MEM_ACK = ((ack_on != 0) && (n == ack_on)) || force_ack;
      end else begin
        n = 0;
        MEM_ACK = force_ack;
      end
      MEM_RDATA = rdata_v;
    end
  end

  // Monitor: request fields on each MEM_REQ cycle, request length on its fall,
  // and result/stall length when HLT drops.
  initial begin
    int hlt_cnt, req_cnt;
    bit have_cur;
    req_t cur;
    rsp_t r;
    hlt_cnt = 0; req_cnt = 0; have_cur = 0;
    forever begin
      @(negedge CLK);
      #1;
      if (!RES) begin
        if (HLT) begin
          hlt_cnt++;
        end else if (hlt_cnt > 0) begin
          if (exp_rsp.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_completion: hlt cycles %0d, none expected", hlt_cnt);
          end else begin
            r = exp_rsp.pop_front();
            chk("datai", DATAI, r.datai);
            chk("err", 32'(ERR), 32'(r.err));
            chk("err_addr", ERR_ADDR, r.eaddr);
            chk("hlt_cycles", 32'(hlt_cnt), 32'(r.hlt));
          end
          hlt_cnt = 0;
        end
      end
      if (MEM_REQ) begin
        if (req_cnt == 0) begin
          if (exp_req.size() == 0) begin
            vectors++; miscompares++; have_cur = 0;
            $display("FAIL unexpected_req: addr %08h, none expected", MEM_ADDR);
          end else begin
            cur = exp_req.pop_front();
            have_cur = 1;
          end
        end
        req_cnt++;
        if (have_cur) begin
          chk("mem_we", 32'(MEM_WE), 32'(cur.we));
          chk("mem_be", 32'(MEM_BE), 32'(cur.be));
          chk("mem_addr", MEM_ADDR, cur.addr);
          chk("mem_wdata", MEM_WDATA, cur.wdata);
        end
      end else if (req_cnt > 0) begin
        if (have_cur) chk("req_cycles", 32'(req_cnt), 32'(cur.len));
        req_cnt = 0;
        have_cur = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RES = 1'b1; DAS = 1'b1; DRD = 1'b1; DWR = 1'b0; DLEN = 3'd4;
    DADDR = 32'h0; DATAO = 32'h0; ERR_CLR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_hlt", 32'(HLT), 32'h0);
    chk("rst_datai", DATAI, 32'h0);
    chk("rst_req", 32'(MEM_REQ), 32'h0);
    chk("rst_be", 32'(MEM_BE), 32'h0);
    chk("rst_addr", MEM_ADDR, 32'h0);
    chk("rst_wdata", MEM_WDATA, 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    chk("rst_err_addr", ERR_ADDR, 32'h0);
    DAS = 1'b0; DRD = 1'b0; RES = 1'b0;

    exp_q(1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 1); exp_r(32'h12345678, 1'b0, 32'h0, 2);
    do_access(1'b1, 1'b0, 3'd4, 32'h100, 32'hDEADBEEF, 1, 32'h12345678, 1'b0);

    exp_q(1'b1, 4'h8, 32'h200, 32'hA5A5A5A5, 2); exp_r(32'h12345678, 1'b0, 32'h0, 3);
    do_access(1'b0, 1'b1, 3'd1, 32'h203, 32'h000000A5, 2, 32'hFFFF0000, 1'b0);

    exp_q(1'b1, 4'hC, 32'h200, 32'hBEEFBEEF, 1); exp_r(32'h12345678, 1'b0, 32'h0, 2);
    do_access(1'b0, 1'b1, 3'd2, 32'h202, 32'h0000BEEF, 1, 32'h0, 1'b0);

    exp_r(32'h0, 1'b1, 32'h201, 1);
    do_access(1'b1, 1'b0, 3'd2, 32'h201, 32'h0, 1, 32'h0, 1'b0);
    clr_err();

    exp_q(1'b0, 4'hF, 32'h400, 32'h0, 4); exp_r(32'h0, 1'b1, 32'h400, 5);
    do_access(1'b1, 1'b0, 3'd4, 32'h400, 32'h0, 0, 32'h0, 1'b0);
    clr_err();

    exp_q(1'b0, 4'hF, 32'h404, 32'h0, 4); exp_r(32'hCAFEF00D, 1'b0, 32'h0, 5);
    do_access(1'b1, 1'b0, 3'd4, 32'h404, 32'h0, 4, 32'hCAFEF00D, 1'b0);

    exp_q(1'b0, 4'h2, 32'h404, 32'h12121212, 1); exp_r(32'h11223344, 1'b0, 32'h0, 2);
    do_access(1'b1, 1'b0, 3'd1, 32'h405, 32'h00000012, 1, 32'h11223344, 1'b0);

    // DAS with neither read nor write must not stall or request.
    @(negedge CLK);
    DAS = 1'b1; DADDR = 32'h900;
    @(negedge CLK);
    chk("das_only_hlt", 32'(HLT), 32'h0);
    DAS = 1'b0;

    exp_r(32'h0, 1'b1, 32'h11, 1);
    do_access(1'b1, 1'b0, 3'd4, 32'h11, 32'h0, 1, 32'h0, 1'b0);
    exp_r(32'h0, 1'b1, 32'h11, 1);
    do_access(1'b0, 1'b1, 3'd2, 32'h23, 32'h1234, 1, 32'h0, 1'b0);
    exp_r(32'h0, 1'b1, 32'h35, 1);
    do_access(1'b1, 1'b0, 3'd4, 32'h35, 32'h0, 1, 32'h0, 1'b1);

    exp_q(1'b0, 4'hF, 32'h800, 32'h0, 1); exp_r(32'h55AA55AA, 1'b1, 32'h35, 2);
    do_access(1'b1, 1'b0, 3'd4, 32'h800, 32'h0, 1, 32'h55AA55AA, 1'b0);
    exp_r(32'h0, 1'b1, 32'h35, 1);
    do_access(1'b1, 1'b0, 3'd3, 32'h500, 32'h0, 1, 32'h0, 1'b0);
    exp_q(1'b0, 4'hF, 32'h804, 32'h0, 1); exp_r(32'h0F0F0F0F, 1'b1, 32'h35, 2);
    do_access(1'b1, 1'b0, 3'd4, 32'h804, 32'h0, 1, 32'h0F0F0F0F, 1'b0);
    exp_r(32'h0, 1'b1, 32'h35, 1);
    do_access(1'b1, 1'b1, 3'd4, 32'h600, 32'h0, 1, 32'h0, 1'b0);

    // Reset while the memory is still owing an ack, then a stray ack.
    exp_q(1'b0, 4'hF, 32'h700, 32'h0, 2); exp_r(32'h0, 1'b0, 32'h0, 2);
    @(negedge CLK);
    ack_on = 0;
    DAS = 1'b1; DRD = 1'b1; DWR = 1'b0; DLEN = 3'd4; DADDR = 32'h700;
    @(negedge CLK);
    @(negedge CLK);
    RES = 1'b1; DAS = 1'b0; DRD = 1'b0;
    @(negedge CLK);
    RES = 1'b0; force_ack = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    repeat (4) @(negedge CLK);
    chk("post_rst_req", 32'(MEM_REQ), 32'h0);
    chk("post_rst_hlt", 32'(HLT), 32'h0);
    chk("post_rst_datai", DATAI, 32'h0);
    chk("req_queue_empty", 32'(exp_req.size()), 32'h0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
